// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 15;
    localparam int WORD_W_DEF  = 32;
    localparam int DATA_W_DEF  = 16;
    localparam int INSTR_W_DEF = 25;
    localparam int BUF_EN_DEF  = 1;

    localparam logic [15:0] HIT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        F_RD,
        F_WAIT,
        D_RD,
        D_WAIT,
        D_WR,
        ACK
    } state_t;

    // Ceiling log2, used for the lane-select width.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_linebuf.sv
// One-word data line buffer: tag/valid/word storage, hit compare, lane extract and lane merge.
module mem_arb_linebuf #(
    parameter int TAG_W  = 15,
    parameter int WORD_W = 32,
    parameter int DATA_W = 16,
    parameter int LSEL_W = 1,
    parameter int BUF_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [TAG_W-1:0]  lookup_tag,
    input  logic [LSEL_W-1:0] lane,
    input  logic [DATA_W-1:0] wdata,
    input  logic              use_mem,
    input  logic [WORD_W-1:0] mem_word,
    output logic              hit,
    output logic [DATA_W-1:0] lane_data,
    output logic [WORD_W-1:0] merged
);

    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            word  <= wr_word;
        end
    end

    // Source word is either the buffered copy or the word just returned by memory.
    assign src       = use_mem ? mem_word : word;
    assign hit       = (BUF_EN != 0) && valid && (tag == lookup_tag);
    assign lane_data = src[int'(lane)*DATA_W +: DATA_W];

    always_comb begin
        merged = src;
        merged[int'(lane)*DATA_W +: DATA_W] = wdata;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of one word memory between an instruction-fetch port and a
// narrower load/store port; sub-word stores are read-modify-write via a line buffer.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int BUF_EN  = BUF_EN_DEF,
    localparam int LSEL_W = log2(WORD_W / DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDR_W-1:0]        if_addr,
    output logic                     if_ack,
    output logic [INSTR_W-1:0]       if_data,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDR_W+LSEL_W-1:0] d_addr,
    input  logic [DATA_W-1:0]        d_wdata,
    output logic                     d_ack,
    output logic [DATA_W-1:0]        d_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WORD_W-1:0]        mem_wdata,
    output logic                     mem_we,
    output logic                     mem_readstart,
    input  logic [WORD_W-1:0]        mem_rdata,
    input  logic                     mem_readrdy,
    input  logic                     mem_saverdy,
    output logic                     busy,
    output logic [15:0]              hit_cnt
);

    state_t state;
    logic   last_fetch;
    logic   gnt_data;
    logic   lat_we;
    logic [ADDR_W-1:0] lat_tag;
    logic [LSEL_W-1:0] lat_lane;
    logic [DATA_W-1:0] lat_wdata;

    logic [ADDR_W-1:0] cur_tag;
    logic [LSEL_W-1:0] cur_lane;
    logic [DATA_W-1:0] cur_wdata;
    logic              pick_data;
    logic              pick_fetch;
    logic              hit;
    logic [DATA_W-1:0] lane_data;
    logic [WORD_W-1:0] merged;
    logic              buf_wr;
    logic [WORD_W-1:0] buf_word;

    // Live request fields while idle, latched copies once a data request is granted.
    always_comb begin
        if (state == IDLE) begin
            cur_tag   = d_addr[ADDR_W+LSEL_W-1:LSEL_W];
            cur_lane  = d_addr[LSEL_W-1:0];
            cur_wdata = d_wdata;
        end else begin
            cur_tag   = lat_tag;
            cur_lane  = lat_lane;
            cur_wdata = lat_wdata;
        end
    end

    always_comb begin
        pick_data  = d_req && (!if_req || last_fetch);
        pick_fetch = if_req && !pick_data;
    end

    assign buf_wr   = ((state == IDLE) && pick_data && d_we && hit)
                    || ((state == D_WAIT) && mem_readrdy);
    assign buf_word = ((state == D_WAIT) && !lat_we) ? mem_rdata : merged;
    assign busy     = (state != IDLE);

    mem_arb_linebuf #(
        .TAG_W  (ADDR_W),
        .WORD_W (WORD_W),
        .DATA_W (DATA_W),
        .LSEL_W (LSEL_W),
        .BUF_EN (BUF_EN)
    ) u_linebuf (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (buf_wr),
        .wr_tag     (cur_tag),
        .wr_word    (buf_word),
        .lookup_tag (cur_tag),
        .lane       (cur_lane),
        .wdata      (cur_wdata),
        .use_mem    (state == D_WAIT),
        .mem_word   (mem_rdata),
        .hit        (hit),
        .lane_data  (lane_data),
        .merged     (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_fetch    <= 1'b1;
            gnt_data      <= 1'b0;
            lat_we        <= 1'b0;
            lat_tag       <= '0;
            lat_lane      <= '0;
            lat_wdata     <= '0;
            if_ack        <= 1'b0;
            if_data       <= '0;
            d_ack         <= 1'b0;
            d_rdata       <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_readstart <= 1'b0;
            hit_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_data) begin
                        gnt_data  <= 1'b1;
                        lat_we    <= d_we;
                        lat_tag   <= cur_tag;
                        lat_lane  <= cur_lane;
                        lat_wdata <= cur_wdata;
                        mem_addr  <= cur_tag;
                        if (hit) begin
                            if (hit_cnt != HIT_MAX) hit_cnt <= hit_cnt + 16'd1;
                            if (d_we) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= merged;
                                state     <= D_WR;
                            end else begin
                                d_rdata <= lane_data;
                                d_ack   <= 1'b1;
                                state   <= ACK;
                            end
                        end else begin
                            mem_readstart <= 1'b1;
                            state         <= D_RD;
                        end
                    end else if (pick_fetch) begin
                        gnt_data      <= 1'b0;
                        mem_addr      <= if_addr;
                        mem_readstart <= 1'b1;
                        state         <= F_RD;
                    end
                end
                F_RD: begin
                    mem_readstart <= 1'b0;
                    state         <= F_WAIT;
                end
                F_WAIT: begin
                    if (mem_readrdy) begin
                        if_data <= mem_rdata[INSTR_W-1:0];
                        if_ack  <= 1'b1;
                        state   <= ACK;
                    end
                end
                D_RD: begin
                    mem_readstart <= 1'b0;
                    state         <= D_WAIT;
                end
                D_WAIT: begin
                    if (mem_readrdy) begin
                        if (lat_we) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= merged;
                            state     <= D_WR;
                        end else begin
                            d_rdata <= lane_data;
                            d_ack   <= 1'b1;
                            state   <= ACK;
                        end
                    end
                end
                D_WR: begin
                    if (mem_saverdy) begin
                        mem_we <= 1'b0;
                        d_ack  <= 1'b1;
                        state  <= ACK;
                    end
                end
                ACK: begin
                    if_ack     <= 1'b0;
                    d_ack      <= 1'b0;
                    last_fetch <= !gnt_data;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
